iter_alu: RTL and testbench
===========================

Name: iter_alu

Overview:
- Multi-cycle execution unit that consumes the 4-bit ALUControl code from the ALU decoder, plus operands A/B.
- Returns a registered result through a start/busy/done handshake.
- Logic/arithmetic/compare ops complete in one cycle. Shifts run iteratively, 1 bit position per cycle, to save a barrel shifter.
- Sits in the multi-cycle datapath between the register-read stage and the writeback mux.

Parameters:
- WIDTH, 32, operand/result width in bits (power of two, >= 8).
- SHW, $clog2(WIDTH), shift-amount width; shamt = B[SHW-1:0].

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- ALUControl  input  4  operation code, captured with start
- SrcA  input  WIDTH  operand A, captured with start
- SrcB  input  WIDTH  operand B / shift amount, captured with start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse; result valid
- ALUResult  output  WIDTH  registered result; holds until next done
- Zero  output  1  registered (ALUResult == 0), updated with ALUResult
- illegal  output  1  registered; set with done when code undefined

Behaviour:
- Reset (synchronous, priority over everything): state=IDLE; busy=0, done=0, ALUResult=0, Zero=1, illegal=0. Reset mid-shift aborts the operation; no done is issued.
- Opcodes:
  - 0000 add
  - 0001 sub
  - 0010 and
  - 0011 or
  - 0100 xor
  - 0101 slt (signed, result 0/1)
  - 0110 sll
  - 0111 srl
  - 1000 sltu
  - 1111 sra
  - All other codes: result 0, illegal=1.
- Add/sub wrap modulo 2^WIDTH; no overflow output.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - On start=1, latch op/A/shamt.
  - Non-shift op: compute, go to FINISH.
  - Shift op with shamt=0: result=A, go to FINISH.
  - Otherwise: go to SHIFT with working reg=A and count=shamt.
  - busy rises the cycle after start.
- SHIFT: each cycle, shift the working reg 1 position and decrement count.
  - sll: fill 0.
  - srl: fill 0.
  - sra: fill with the MSB.
  - When count reaches 1 (last shift performed this cycle), go to FINISH.
- FINISH (one cycle):
  - Load ALUResult, Zero, illegal; done=1; busy=0; go to IDLE.
  - done is registered, so it is high during the FINISH-exit cycle.
- Latency, start cycle T to done high:
  - Non-shift or shamt=0: done at T+2 (the edge at T+1 enters FINISH, the edge at T+2 asserts done).
  - Shift by n>0: done at T+2+n.
- Handshake:
  - start while busy=1 or during the done cycle is ignored. No queueing.
  - start in the cycle immediately after done is accepted.
  - Inputs need only be valid in the start cycle; later changes have no effect.
- ALUResult/Zero/illegal change only on done or reset.
- illegal clears on the next done with a legal code.

Test Plan:
- Reset, then idle 3 cycles -> busy=0, done=0, ALUResult=0, Zero=1, illegal=0.
- start, code 0001, A=5, B=7 -> done exactly 2 cycles later, ALUResult=0xFFFFFFFE, Zero=0; code 0000, A=0xFFFFFFFF, B=1 -> ALUResult=0, Zero=1.
- Compare ops:
  - slt, A=0xFFFFFFFF, B=1 -> 1.
  - sltu, same operands -> 0.
  - code 1010 -> ALUResult=0, illegal=1.
  - Following add -> illegal=0.
- Shifts, each checked for exact latency:
  - sra A=0x80000000, B=31 -> 0xFFFFFFFF, done at T+33.
  - srl same operands -> 0x00000001.
  - sll A=1, B=0x25 (shamt=5) -> 0x20, done at T+7.
  - sll A=0x1234, B=0 -> 0x1234, done at T+2.
- Handshake:
  - start pulses while busy during a 10-bit shift -> ignored; exactly one done.
  - Back-to-back start the cycle after done -> accepted, correct second result.
- Assert reset at cycle 4 of a 20-bit shift -> no done pulse, busy=0, ALUResult=0 next cycle; a new add afterwards completes normally.

Source files
------------

// File: rtl/iter_alu.sv
// rtl/iter_alu.sv - multi-cycle ALU: single-cycle logic/arith/compare, iterative 1-bit-per-cycle shifts
module iter_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             illegal
);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1111;

    state_t           state_q, state_d;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] work_q;
    logic [SHW-1:0]   count_q;
    logic             ill_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;

    logic             accept;
    logic             is_shift;
    logic             legal;
    logic [WIDTH-1:0] alu_val;
    logic [WIDTH-1:0] shifted;
    logic [SHW-1:0]   shamt;

    // A start landing in the done cycle is dropped; the next cycle accepts.
    assign accept   = (state_q == IDLE) && start && !done_q;
    assign shamt    = SrcB[SHW-1:0];
    assign is_shift = (ALUControl == OP_SLL) || (ALUControl == OP_SRL) || (ALUControl == OP_SRA);

    always_comb begin
        alu_val = '0;
        legal   = 1'b1;
        case (ALUControl)
            OP_ADD:  alu_val = SrcA + SrcB;
            OP_SUB:  alu_val = SrcA - SrcB;
            OP_AND:  alu_val = SrcA & SrcB;
            OP_OR:   alu_val = SrcA | SrcB;
            OP_XOR:  alu_val = SrcA ^ SrcB;
            OP_SLT:  alu_val = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
            OP_SLTU: alu_val = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
            OP_SLL, OP_SRL, OP_SRA: alu_val = SrcA;
            default: begin
                alu_val = '0;
                legal   = 1'b0;
            end
        endcase
    end

    always_comb begin
        shifted = work_q;
        case (op_q)
            OP_SLL:  shifted = {work_q[WIDTH-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, work_q[WIDTH-1:1]};
            default: shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept)
                    state_d = (is_shift && shamt != '0) ? SHIFT : FINISH;
            end
            SHIFT: begin
                if (count_q == SHW'(1))
                    state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            work_q    <= '0;
            count_q   <= '0;
            ill_q     <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= ALUControl;
                        work_q  <= alu_val;
                        count_q <= shamt;
                        ill_q   <= ~legal;
                    end
                end
                SHIFT: begin
                    work_q  <= shifted;
                    count_q <= count_q - SHW'(1);
                end
                FINISH: begin
                    done_q    <= 1'b1;
                    result_q  <= work_q;
                    zero_q    <= (work_q == '0);
                    illegal_q <= ill_q;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_iter_alu.sv
// tb/tb_iter_alu.sv - directed-vector bench for iter_alu
module tb_iter_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic        done;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        illegal;

    int vectors = 0;
    int miscompares = 0;

    iter_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
        .ALUResult(ALUResult), .Zero(Zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Issues one op at #1 after an edge; lat counts edges from start until done is seen.
    task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        @(posedge clk); #1;
        ALUControl = code; SrcA = a; SrcB = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; SrcA = 32'hDEAD_BEEF; SrcB = 32'h5A5A_5A5A; ALUControl = 4'b0011;
        lat = 1;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; ALUControl = '0; SrcA = '0; SrcB = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, ALUResult, Zero, illegal} !== {1'b0, 1'b0, 32'h0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b res=%h zero=%b ill=%b required 0 0 0 1 0",
                     busy, done, ALUResult, Zero, illegal);
        end
    endtask

    task automatic test_arith;
        int lat;
        run_op(4'b0001, 32'd5, 32'd7, lat);
        vectors++;
        if (lat !== 2 || ALUResult !== 32'hFFFF_FFFE || Zero !== 1'b0) begin
            miscompares++;
            $display("FAIL sub: lat=%0d res=%h zero=%b required 2 fffffffe 0", lat, ALUResult, Zero);
        end
        run_op(4'b0000, 32'hFFFF_FFFF, 32'd1, lat);
        vectors++;
        if (lat !== 2 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
            miscompares++;
            $display("FAIL add_wrap: lat=%0d res=%h zero=%b required 2 00000000 1", lat, ALUResult, Zero);
        end
    endtask

    task automatic test_logic;
        int lat;
        logic [3:0]  codes [3] = '{4'b0010, 4'b0011, 4'b0100};
        logic [31:0] exp   [3] = '{32'h0000_F000, 32'h0000_FFF0, 32'h0000_0FF0};
        for (int i = 0; i < 3; i++) begin
            run_op(codes[i], 32'h0000_F0F0, 32'h0000_FF00, lat);
            vectors++;
            if (lat !== 2 || ALUResult !== exp[i]) begin
                miscompares++;
                $display("FAIL logic_op%0d: lat=%0d res=%h required 2 %h", i, lat, ALUResult, exp[i]);
            end
        end
    endtask

    task automatic test_compare;
        int lat;
        run_op(4'b0101, 32'hFFFF_FFFF, 32'd1, lat);
        vectors++;
        if (ALUResult !== 32'd1 || illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL slt: res=%h ill=%b required 00000001 0", ALUResult, illegal);
        end
        run_op(4'b1000, 32'hFFFF_FFFF, 32'd1, lat);
        vectors++;
        if (ALUResult !== 32'd0 || Zero !== 1'b1) begin
            miscompares++;
            $display("FAIL sltu: res=%h zero=%b required 00000000 1", ALUResult, Zero);
        end
        run_op(4'b0011, 32'h1, 32'h2, lat);
        run_op(4'b1010, 32'h1234, 32'h5678, lat);
        vectors++;
        if (lat !== 2 || ALUResult !== 32'd0 || illegal !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_code: lat=%0d res=%h ill=%b required 2 00000000 1", lat, ALUResult, illegal);
        end
        run_op(4'b0000, 32'd2, 32'd3, lat);
        vectors++;
        if (ALUResult !== 32'd5 || illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_clear: res=%h ill=%b required 00000005 0", ALUResult, illegal);
        end
    endtask

    task automatic test_shift;
        int lat;
        logic [3:0]  codes [4] = '{4'b1111, 4'b0111, 4'b0110, 4'b0110};
        logic [31:0] a     [4] = '{32'h8000_0000, 32'h8000_0000, 32'h1, 32'h1234};
        logic [31:0] b     [4] = '{32'd31, 32'd31, 32'h25, 32'h0};
        logic [31:0] exp   [4] = '{32'hFFFF_FFFF, 32'h1, 32'h20, 32'h1234};
        int          elat  [4] = '{33, 33, 7, 2};
        for (int i = 0; i < 4; i++) begin
            run_op(codes[i], a[i], b[i], lat);
            vectors++;
            if (lat !== elat[i] || ALUResult !== exp[i]) begin
                miscompares++;
                $display("FAIL shift%0d: lat=%0d res=%h required %0d %h", i, lat, ALUResult, elat[i], exp[i]);
            end
        end
        run_op(4'b1111, 32'h4000_0000, 32'd4, lat);
        vectors++;
        if (lat !== 6 || ALUResult !== 32'h0400_0000) begin
            miscompares++;
            $display("FAIL sra_pos: lat=%0d res=%h required 6 04000000", lat, ALUResult);
        end
    endtask

    task automatic test_busy_ignore;
        int dones = 0;
        @(posedge clk); #1;
        ALUControl = 4'b0110; SrcA = 32'd3; SrcB = 32'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            start = (c % 3 == 1) || done;
            ALUControl = 4'b0000; SrcA = 32'd100 + c; SrcB = 32'd1;
            @(posedge clk); #1;
            if (done) begin
                dones++;
                vectors++;
                if (ALUResult !== 32'h0000_0C00) begin
                    miscompares++;
                    $display("FAIL busy_ignore_res: res=%h required 00000c00", ALUResult);
                end
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL done_cycle_start: busy=%b required 0", busy);
                end
                break;
            end
        end
        start = 1'b0;
        vectors++;
        if (dones !== 1) begin
            miscompares++;
            $display("FAIL busy_ignore_count: dones=%0d required 1", dones);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        run_op(4'b0000, 32'd10, 32'd20, lat);
        run_op(4'b0001, 32'd50, 32'd8, lat);
        vectors++;
        if (lat !== 2 || ALUResult !== 32'd42) begin
            miscompares++;
            $display("FAIL back_to_back: lat=%0d res=%h required 2 0000002a", lat, ALUResult);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse_width: done=%b required 0", done);
        end
    endtask

    task automatic test_reset_abort;
        int lat;
        int seen = 0;
        @(posedge clk); #1;
        ALUControl = 4'b0110; SrcA = 32'h1; SrcB = 32'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_abort: done=%b busy=%b res=%h zero=%b required 0 0 0 1",
                     done, busy, ALUResult, Zero);
        end
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL reset_abort_nodone: dones=%0d required 0", seen);
        end
        run_op(4'b0000, 32'd7, 32'd8, lat);
        vectors++;
        if (lat !== 2 || ALUResult !== 32'd15) begin
            miscompares++;
            $display("FAIL after_reset_add: lat=%0d res=%h required 2 0000000f", lat, ALUResult);
        end
    endtask

    initial begin
        test_reset;
        test_arith;
        test_logic;
        test_compare;
        test_shift;
        test_busy_ignore;
        test_back_to_back;
        test_reset_abort;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
